prach_ditfft3_bf2_p: RTL and testbench
======================================

Name: prach_ditfft3_bf2_p

Overview:
Parametrised radix-3 DIT butterfly (second stage) for the PRACH long-sequence FFT pipeline; the next generation of the fixed 18-bit stage.
- Consumes a streamed triplet (s0,s1,s2) and emits y0=s0+s1, y1=s0-s1/2, y2=±j·(√3/2)·s2 in the same slots, fixed latency.
- Adds generic data width, runtime forward/inverse direction, rounded products and triplet-framing error detection.
- Sits between the radix-3 first stage and the twiddle multiplier.

Parameters:
DW, 18, data width of each I/Q component (min 8).
CW, 18, coefficient width; C = round(√3/2 · 2^(CW-2)), so 56756 for CW=18.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
dir  in  1  0 = forward (+j·C·s2), 1 = inverse (−j·C·s2); sampled with each k=0 sample
din_dr  in  DW  input real, signed
din_di  in  DW  input imag, signed
din_dv  in  1  input valid
sync_in  in  1  marks the k=0 sample of a triplet (qualified by din_dv)
dout_dr  out  DW  output real
dout_di  out  DW  output imag
dout_dv  out  1  output valid
sync_out  out  1  aligned with the dout_dv of a synced y0
err  out  1  one-cycle pulse on a framing error
sat  out  1  one-cycle pulse when an output was clipped (macro only)

Behaviour:
- Reset: all outputs 0, phase k=0, internal pipeline valid bits cleared. Reset asynchronous, mid-operation reset drops any in-flight triplet.
- Phase k counts valid samples 0,1,2,0…
  - sync_in&din_dv forces the current sample to k=0.
  - sync_in without din_dv is ignored.
- Framing:
  - A triplet occupies three consecutive din_dv cycles. Gaps are allowed only between triplets.
  - If din_dv is low while k∈{1,2}: err pulses, k returns to 0, and the partial triplet is discarded (no dout_dv for any of its slots).
  - If sync_in&din_dv arrives while k≠0: err pulses, the partial triplet is discarded, and the new sample starts a triplet at k=0.
- Latency: output slot k appears exactly 5 cycles after input slot k. dout_dv and sync_out are the delayed din_dv and sync_in, gated by the discard logic.
- Arithmetic, in DW+1 bits before narrowing:
  - y0 = s0 + s1.
  - y1 = s0 − ((s1 + 1) >>> 1), i.e. s1/2 rounded half-up.
  - y2 forward: (−C·s2i, C·s2r). y2 inverse: (C·s2i, −C·s2r).
  - For y2, the product is DW+CW bits, plus 2^(CW-3), arithmetic shift right by CW-2, take low DW+1 bits.
- Narrowing to DW: wrap (keep low DW bits) unless the macro below is defined.
- dir latched on k=0 and held for the whole triplet. A dir change at k=1 or k=2 has no effect until the next triplet.
- Between valid outputs, dout_dr and dout_di hold their last value.

Optional Feature:
PRACH_BF3_SAT_EN
- Defined: y0, y1 and y2 saturate to [−2^(DW-1), 2^(DW-1)−1], and sat pulses in the same cycle as the clipped output's dout_dv.
- Undefined: two's-complement wrap and sat tied to 0. Latency is 5 in both builds.

Test Plan:
1. DW=18, dir=0, continuous triplet s0=(1000,−2000), s1=(3000,500), s2=(4000,−4000) with sync on s0 -> 5 cycles later y0=(4000,−1500), y1=(−500,−2250), y2=(3464,3464); sync_out on y0; err=0.
2. Same triplet with dir=1 -> y2=(−3464,−3464); y0 and y1 unchanged. Toggle dir during s2 -> y2 unaffected.
3. s0=(131071,0), s1=(131071,0) -> y0 real = 131071 with sat=1 when the macro is defined; −2 with sat=0 when undefined.
4. s0=(−131072,0), s1=(131071,0) -> y1 real = −131072 saturated (macro defined), wraps to 65536 when undefined.
5. din_dv dropped after s1 -> err pulse, no dout_dv for y0 or y1 of that triplet; the next synced triplet is produced correctly.
6. sync_in at k=2 -> err pulse, old triplet discarded, new triplet aligned to the sync. 100 random continuous triplets vs. golden model -> bit-exact, latency 5.

Source files
------------

// File: rtl/prach_ditfft3_bf2_p_if.sv
// Stream bundle for the radix-3 second-stage butterfly: input triplet samples
// with framing/direction controls, and delayed butterfly outputs with status pulses.
interface prach_ditfft3_bf2_p_if #(
    parameter int DW = 18
);
    logic                 dir;
    logic signed [DW-1:0] din_dr;
    logic signed [DW-1:0] din_di;
    logic                 din_dv;
    logic                 sync_in;
    logic signed [DW-1:0] dout_dr;
    logic signed [DW-1:0] dout_di;
    logic                 dout_dv;
    logic                 sync_out;
    logic                 err;
    logic                 sat;

    modport master (
        output dir, din_dr, din_di, din_dv, sync_in,
        input  dout_dr, dout_di, dout_dv, sync_out, err, sat
    );

    modport slave (
        input  dir, din_dr, din_di, din_dv, sync_in,
        output dout_dr, dout_di, dout_dv, sync_out, err, sat
    );
endinterface

// File: rtl/prach_ditfft3_bf2_p.sv
// Radix-3 DIT second-stage butterfly: y0=s0+s1, y1=s0-s1/2, y2=+/-j*C*s2, 5-cycle latency.
// Define PRACH_BF3_SAT_EN to saturate outputs and drive sat; otherwise outputs wrap.
module prach_ditfft3_bf2_p #(
    parameter int DW = 18,
    parameter int CW = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prach_ditfft3_bf2_p_if.slave bus_io
);
    localparam int NS = 5;
    localparam int PW = DW + CW;
    localparam int EW = 2 * DW + 1;

    function automatic logic [63:0] isqrt64(input logic [63:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = 64'd0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= n) r = t;
            else            r = r;
        end
        return r;
    endfunction

    // round(sqrt(3)/2 * 2^(CW-2)) computed as round-half-up of isqrt(3 * 2^(2CW-4)) / 2
    localparam logic [63:0]   C2  = isqrt64(64'd3 << (2 * CW - 4));
    localparam logic [CW-1:0] C   = CW'((C2 + 64'd1) >> 1);
    localparam logic [PW-1:0] RND = {{(PW - 1){1'b0}}, 1'b1} << (CW - 3);

    function automatic logic [DW:0] sx(input logic [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    function automatic logic [DW:0] rnd(input logic [PW-1:0] p);
        logic [PW-1:0] t;
        t = p + RND;
        return t[CW-2 +: DW + 1];
    endfunction

    // Returns {clipped, value[DW-1:0]}
    function automatic logic [DW:0] narrow(input logic [DW:0] v);
`ifdef PRACH_BF3_SAT_EN
        if (v[DW] != v[DW-1]) return {1'b1, v[DW], {(DW - 1){~v[DW]}}};
        else                  return {1'b0, v[DW-1:0]};
`else
        return {1'b0, v[DW-1:0]};
`endif
    endfunction

    logic [1:0]    k_q, k_d, eff_k_s, squash_s;
    logic          err_s, dir_q;
    logic [DW-1:0] s0r_q, s0i_q;
    logic [NS-1:0] v_q, v_d, sy_q;
    logic [EW-1:0] dat_q [NS];
    logic [PW-1:0] pr_s, pi_s;
    logic [DW:0]   n0r_s, n0i_s, n1r_s, n1i_s, n2r_s, n2i_s, h_s;
    logic [EW-1:0] y0_e_s, ent0_s;
    logic          ld_y0_s;

    logic [DW-1:0] dout_dr_q, dout_di_q;
    logic          dout_dv_q, sync_out_q, err_q, sat_q;

    // Framing: effective phase of the current sample, next phase, and partial-triplet squash
    always_comb begin
        eff_k_s  = k_q;
        squash_s = 2'd0;
        err_s    = 1'b0;
        k_d      = k_q;
        if (bus_io.din_dv) begin
            if (bus_io.sync_in) begin
                eff_k_s  = 2'd0;
                squash_s = k_q;
                err_s    = (k_q != 2'd0);
            end else begin
                eff_k_s  = k_q;
            end
            k_d = (eff_k_s == 2'd2) ? 2'd0 : eff_k_s + 2'd1;
        end else begin
            squash_s = k_q;
            err_s    = (k_q != 2'd0);
            k_d      = 2'd0;
        end
        v_d = {v_q[NS-2:0], bus_io.din_dv};
        if (squash_s != 2'd0) v_d[1] = 1'b0;
        else                  v_d[1] = v_d[1];
        if (squash_s == 2'd2) v_d[2] = 1'b0;
        else                  v_d[2] = v_d[2];
    end

    // Butterfly arithmetic on the incoming sample (s1 or s2) and the held s0
    always_comb begin
        pr_s  = $signed({{CW{bus_io.din_dr[DW-1]}}, bus_io.din_dr}) * $signed({{DW{1'b0}}, C});
        pi_s  = $signed({{CW{bus_io.din_di[DW-1]}}, bus_io.din_di}) * $signed({{DW{1'b0}}, C});
        n0r_s = narrow(sx(s0r_q) + sx(bus_io.din_dr));
        n0i_s = narrow(sx(s0i_q) + sx(bus_io.din_di));
        h_s   = sx(bus_io.din_dr) + {{DW{1'b0}}, 1'b1};
        n1r_s = narrow(sx(s0r_q) - {h_s[DW], h_s[DW:1]});
        h_s   = sx(bus_io.din_di) + {{DW{1'b0}}, 1'b1};
        n1i_s = narrow(sx(s0i_q) - {h_s[DW], h_s[DW:1]});
        if (dir_q) begin
            n2r_s = narrow(rnd(pi_s));
            n2i_s = narrow(rnd(-pr_s));
        end else begin
            n2r_s = narrow(rnd(-pi_s));
            n2i_s = narrow(rnd(pr_s));
        end
        y0_e_s  = {n0r_s[DW] | n0i_s[DW], n0r_s[DW-1:0], n0i_s[DW-1:0]};
        ld_y0_s = bus_io.din_dv && (eff_k_s == 2'd1);
        case (eff_k_s)
            2'd1:    ent0_s = {n1r_s[DW] | n1i_s[DW], n1r_s[DW-1:0], n1i_s[DW-1:0]};
            2'd2:    ent0_s = {n2r_s[DW] | n2i_s[DW], n2r_s[DW-1:0], n2i_s[DW-1:0]};
            default: ent0_s = {EW{1'b0}};
        endcase
    end

    // Phase, s0/dir capture, slot pipeline (y0 back-filled into its own slot) and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= 2'd0;
            dir_q      <= 1'b0;
            s0r_q      <= {DW{1'b0}};
            s0i_q      <= {DW{1'b0}};
            v_q        <= {NS{1'b0}};
            sy_q       <= {NS{1'b0}};
            for (int i = 0; i < NS; i++) dat_q[i] <= {EW{1'b0}};
            dout_dr_q  <= {DW{1'b0}};
            dout_di_q  <= {DW{1'b0}};
            dout_dv_q  <= 1'b0;
            sync_out_q <= 1'b0;
            err_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            k_q   <= k_d;
            err_q <= err_s;
            if (bus_io.din_dv && (eff_k_s == 2'd0)) begin
                s0r_q <= bus_io.din_dr;
                s0i_q <= bus_io.din_di;
                dir_q <= bus_io.dir;
            end
            v_q      <= v_d;
            sy_q     <= {sy_q[NS-2:0], bus_io.din_dv & bus_io.sync_in};
            dat_q[0] <= ent0_s;
            dat_q[1] <= ld_y0_s ? y0_e_s : dat_q[0];
            for (int i = 2; i < NS; i++) dat_q[i] <= dat_q[i-1];
            if (v_q[NS-1]) begin
                dout_dr_q  <= dat_q[NS-1][2*DW-1:DW];
                dout_di_q  <= dat_q[NS-1][DW-1:0];
                dout_dv_q  <= 1'b1;
                sync_out_q <= sy_q[NS-1];
                sat_q      <= dat_q[NS-1][2*DW];
            end else begin
                dout_dv_q  <= 1'b0;
                sync_out_q <= 1'b0;
                sat_q      <= 1'b0;
            end
        end
    end

    assign bus_io.dout_dr  = dout_dr_q;
    assign bus_io.dout_di  = dout_di_q;
    assign bus_io.dout_dv  = dout_dv_q;
    assign bus_io.sync_out = sync_out_q;
    assign bus_io.err      = err_q;
    assign bus_io.sat      = sat_q;
endmodule

// File: tb/tb_prach_ditfft3_bf2_p.sv
// Self-checking bench for prach_ditfft3_bf2_p: directed framing/arithmetic cases plus
// random triplets against a queue-based reference model of the triplet rules.
module tb_prach_ditfft3_bf2_p;
    localparam int     DW  = 18;
    localparam int     CW  = 18;
    localparam longint CK  = 56756;
    localparam int     LAT = 5;
    localparam int     NC  = 4096;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    prach_ditfft3_bf2_p_if #(.DW(DW)) bus ();
    prach_ditfft3_bf2_p #(.DW(DW), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

    typedef struct {
        longint re;
        longint im;
        bit     sy;
        bit     dir;
        int     e;
    } smp_t;

    int     cyc, n_tests, n_fail;
    bit     exp_dv [NC];
    bit     exp_sy [NC];
    bit     exp_sat[NC];
    bit     exp_err[NC];
    longint exp_re [NC];
    longint exp_im [NC];
    smp_t   pend[$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic longint fit(input longint v, output bit s);
        longint hi, lo;
        hi = (longint'(1) <<< (DW - 1)) - 1;
        lo = -(longint'(1) <<< (DW - 1));
        s  = 1'b0;
`ifdef PRACH_BF3_SAT_EN
        if (v > hi) begin s = 1'b1; return hi; end
        if (v < lo) begin s = 1'b1; return lo; end
        return v;
`else
        begin
            logic [DW-1:0] w;
            w = v[DW-1:0];
            return longint'($signed(w));
        end
`endif
    endfunction

    function automatic longint rnd(input longint p);
        return (p + (longint'(1) <<< (CW - 3))) >>> (CW - 2);
    endfunction

    function automatic longint rv();
        logic [31:0]   r;
        logic [DW-1:0] w;
        r = $urandom;
        w = r[DW-1:0];
        return longint'($signed(w));
    endfunction

    task automatic emit();
        longint yr[3], yi[3];
        bit     s1, s2;
        int     t;
        yr[0] = pend[0].re + pend[1].re;
        yi[0] = pend[0].im + pend[1].im;
        yr[1] = pend[0].re - ((pend[1].re + 1) >>> 1);
        yi[1] = pend[0].im - ((pend[1].im + 1) >>> 1);
        if (pend[0].dir) begin
            yr[2] = rnd(CK * pend[2].im);
            yi[2] = rnd(-CK * pend[2].re);
        end else begin
            yr[2] = rnd(-CK * pend[2].im);
            yi[2] = rnd(CK * pend[2].re);
        end
        for (int k = 0; k < 3; k++) begin
            t          = pend[k].e + LAT;
            exp_dv[t]  = 1'b1;
            exp_re[t]  = fit(yr[k], s1);
            exp_im[t]  = fit(yi[k], s2);
            exp_sat[t] = s1 | s2;
            exp_sy[t]  = (k == 0) && pend[0].sy;
        end
    endtask

    task automatic model_push(input int e, input bit dv, input bit sy, input bit dr,
                              input longint re, input longint im);
        if (dv) begin
            if (sy && pend.size() != 0) begin
                exp_err[e] = 1'b1;
                pend.delete();
            end
            pend.push_back('{re, im, sy, dr, e});
            if (pend.size() == 3) begin
                emit();
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            exp_err[e] = 1'b1;
            pend.delete();
        end
    endtask

    task automatic check_cycle();
        chk("err", longint'(bus.err), longint'(exp_err[cyc]));
        chk("dout_dv", longint'(bus.dout_dv), longint'(exp_dv[cyc]));
        chk("sync_out", longint'(bus.sync_out), longint'(exp_sy[cyc]));
        chk("sat", longint'(bus.sat), longint'(exp_sat[cyc]));
        if (exp_dv[cyc]) begin
            chk("dout_dr", longint'(bus.dout_dr), exp_re[cyc]);
            chk("dout_di", longint'(bus.dout_di), exp_im[cyc]);
        end
    endtask

    task automatic step(input bit dv, input bit sy, input bit dr, input longint re, input longint im);
        logic [DW-1:0] wr, wi;
        wr = re[DW-1:0];
        wi = im[DW-1:0];
        bus.din_dv  = dv;
        bus.sync_in = sy;
        bus.dir     = dr;
        bus.din_dr  = wr;
        bus.din_di  = wi;
        model_push(cyc + 1, dv, sy, dr, re, im);
        @(posedge clk);
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_dv"}, longint'(bus.dout_dv), 0);
        chk({tag, "_dr"}, longint'(bus.dout_dr), 0);
        chk({tag, "_di"}, longint'(bus.dout_di), 0);
        chk({tag, "_sync"}, longint'(bus.sync_out), 0);
        chk({tag, "_err"}, longint'(bus.err), 0);
        chk({tag, "_sat"}, longint'(bus.sat), 0);
    endtask

    initial begin
        bit sy;
        cyc = 0; n_tests = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.din_dv = 1'b0; bus.sync_in = 1'b0; bus.dir = 1'b0;
        bus.din_dr = '0;   bus.din_di = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Test 1: forward triplet, explicit expected values 5 cycles after each slot
        step(1, 1, 0, 1000, -2000);
        step(1, 0, 0, 3000, 500);
        step(1, 0, 0, 4000, -4000);
        idle(3);
        chk("t1_y0r", longint'(bus.dout_dr), 4000);
        chk("t1_y0i", longint'(bus.dout_di), -1500);
        chk("t1_sync", longint'(bus.sync_out), 1);
        idle(1);
        chk("t1_y1r", longint'(bus.dout_dr), -500);
        chk("t1_y1i", longint'(bus.dout_di), -2250);
        idle(1);
        chk("t1_y2r", longint'(bus.dout_dr), 3464);
        chk("t1_y2i", longint'(bus.dout_di), 3464);

        // Test 2: inverse, dir toggled during s2 must not matter
        step(1, 1, 1, 1000, -2000);
        step(1, 0, 1, 3000, 500);
        step(1, 0, 0, 4000, -4000);
        idle(5);
        chk("t2_y2r", longint'(bus.dout_dr), -3464);
        chk("t2_y2i", longint'(bus.dout_di), -3464);

        // Test 3/4: positive overflow on y0, negative overflow on y1
        step(1, 1, 0, 131071, 0);
        step(1, 0, 0, 131071, 0);
        step(1, 0, 0, 0, 0);
        idle(3);
`ifdef PRACH_BF3_SAT_EN
        chk("t3_y0r", longint'(bus.dout_dr), 131071);
        chk("t3_sat", longint'(bus.sat), 1);
`else
        chk("t3_y0r", longint'(bus.dout_dr), -2);
        chk("t3_sat", longint'(bus.sat), 0);
`endif
        step(1, 1, 0, -131072, 0);
        step(1, 0, 0, 131071, 0);
        step(1, 0, 0, 0, 0);
        idle(4);
`ifdef PRACH_BF3_SAT_EN
        chk("t4_y1r", longint'(bus.dout_dr), -131072);
        chk("t4_sat", longint'(bus.sat), 1);
`else
        chk("t4_y1r", longint'(bus.dout_dr), 65536);
        chk("t4_sat", longint'(bus.sat), 0);
`endif

        // Test 5: din_dv dropped after s1
        step(1, 1, 0, 111, 222);
        step(1, 0, 0, 333, 444);
        idle(1);
        chk("t5_err", longint'(bus.err), 1);
        idle(5);
        step(1, 1, 0, -500, 700);
        step(1, 0, 0, 901, -33);
        step(1, 0, 0, -7777, 12345);
        idle(6);

        // Test 6: sync at k=2 restarts the triplet
        step(1, 1, 0, 10, 20);
        step(1, 0, 0, 30, 40);
        step(1, 1, 1, 50, 60);
        chk("t6_err", longint'(bus.err), 1);
        step(1, 0, 0, 70, -80);
        step(1, 0, 0, -90, 100);
        idle(6);

        // Mid-operation reset drops a triplet that is still in flight
        step(1, 1, 0, 1234, 5678);
        step(1, 0, 0, 4321, 8765);
        step(1, 0, 0, 999, -999);
        idle(1);
        bus.din_dv = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        pend.delete();
        for (int c = cyc; c < NC; c++) begin
            exp_dv[c] = 1'b0; exp_sy[c] = 1'b0; exp_sat[c] = 1'b0; exp_err[c] = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        idle(6);

        // Random triplets, mostly back-to-back with occasional inter-triplet gaps
        for (int t = 0; t < 100; t++) begin
            sy = ($urandom_range(0, 3) != 0);
            step(1, sy, 1'($urandom_range(0, 1)), rv(), rv());
            step(1, 0, 1'($urandom_range(0, 1)), rv(), rv());
            step(1, 0, 1'($urandom_range(0, 1)), rv(), rv());
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
